// File: rtl/inst_write_queue.sv
// Instruction-memory write queue: buffers OP_WR / OP_WRI writes and drains them
// to instruction memory in order under a valid/ready style handshake.
module inst_write_queue #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter logic [5:0]  OP_WR  = 6'b001010,
  parameter logic [5:0]  OP_WRI = 6'b001011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inst_valid,
  input  logic [31:0]              inst,
  input  logic [31:0]              rs,
  input  logic [31:0]              rt,
  output logic                     stall,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ENT_W-1:0]  store_q [DEPTH];

  logic              is_wr;
  logic              is_wri;
  logic              full;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] wr_addr;
  logic              unused_bits;

  assign is_wr   = (inst[31:26] == OP_WR);
  assign is_wri  = (inst[31:26] == OP_WRI);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign accept  = inst_valid && (is_wr || is_wri) && !full;
  assign pop     = (count_q != '0) && mem_ready;
  assign wr_addr = is_wr ? rs[ADDR_W-1:0] : ptr_q;

  // Both opcodes leave the pointer one past the address just written.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ptr_d   = ptr_q;
    if (accept) begin
      tail_d = tail_q + IDX_W'(1);
      ptr_d  = wr_addr + ADDR_W'(1);
    end
    if (pop) begin
      head_d = head_q + IDX_W'(1);
    end
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ptr_q   <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ptr_q   <= ptr_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q[tail_q] <= {wr_addr, rt[DATA_W-1:0]};
    end
  end

  assign stall                 = full;
  assign mem_we                = (count_q != '0);
  assign {mem_addr, mem_wdata} = store_q[head_q];
  assign pending               = count_q;

  assign unused_bits = ^{inst[25:0], rs, rt};

endmodule

// File: tb/tb_inst_write_queue.sv
// Randomized plus directed bench for inst_write_queue with a queue-based
// reference model and a decoupled negedge monitor.
module tb_inst_write_queue;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [5:0]  OP_WR  = 6'b001010;
  localparam logic [5:0]  OP_WRI = 6'b001011;
  localparam logic [5:0]  OP_NOP = 6'b000000;

  logic              clk;
  logic              rst_n;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       rs;
  logic [31:0]       rt;
  logic              stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [2:0]        pending;

  inst_write_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .OP_WR(OP_WR), .OP_WRI(OP_WRI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst), .rs(rs), .rt(rt),
    .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ordered list of writes still owed, occupancy, pointer.
  logic [47:0] exp_q[$];
  logic [15:0] wr_log[$];
  int          model_cnt = 0;
  logic [15:0] model_ptr = '0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy);
    inst_valid = v;
    inst       = {op, 26'($urandom)};
    rs         = a;
    rt         = d;
    mem_ready  = rdy;
  endtask

  // Advance one edge and apply the behavioural rules to the model.
  task automatic tick();
    logic        acc;
    logic        pp;
    logic [15:0] a;
    @(posedge clk);
    if (rst_n) begin
      pp  = (model_cnt != 0) && mem_ready;
      acc = inst_valid && (inst[31:26] == OP_WR || inst[31:26] == OP_WRI) && (model_cnt < DEPTH);
      if (acc) begin
        a = (inst[31:26] == OP_WR) ? rs[15:0] : model_ptr;
        exp_q.push_back({a, rt});
        model_ptr = a + 16'd1;
      end
      model_cnt = model_cnt + int'(acc) - int'(pp);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_cnt = 0;
    model_ptr = '0;
    exp_q.delete();
    #1;
    cmp("rst_mem_we", 64'(mem_we), 64'd0);
    cmp("rst_pending", 64'(pending), 64'd0);
    cmp("rst_stall", 64'(stall), 64'd0);
  endtask

  task automatic idle(input int n);
    drv(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1);
    repeat (n) tick();
  endtask

  task automatic check_log(input string name, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2);
    logic [15:0] ev[3];
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    cmp({name, "_count"}, 64'(wr_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) cmp(name, 64'(wr_log[i]), 64'(ev[i]));
  endtask

  // Monitor: compares state and head entry against the model every cycle.
  always @(negedge clk) begin
    cmp("pending", 64'(pending), 64'(model_cnt));
    cmp("stall", 64'(stall), 64'(model_cnt == DEPTH));
    cmp("mem_we", 64'(mem_we), 64'(model_cnt != 0));
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        cmp("stale_write", 64'(exp_q.size()), 64'd1);
      end else begin
        cmp("head_entry", 64'({mem_addr, mem_wdata}), 64'(exp_q[0]));
        if (mem_ready) begin
          void'(exp_q.pop_front());
          wr_log.push_back(mem_addr);
        end
      end
    end
  end

  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    drv(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0);
    repeat (2) tick();
    cmp("rst_init_pending", 64'(pending), 64'd0);
    cmp("rst_init_mem_we", 64'(mem_we), 64'd0);
    rst_n = 1'b1;

    // Single write, one-cycle latency
    drv(1'b1, OP_WR, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    tick();
    cmp("single_we", 64'(mem_we), 64'd1);
    cmp("single_addr", 64'(mem_addr), 64'h1234);
    cmp("single_data", 64'(mem_wdata), 64'hDEAD_BEEF);
    idle(1);
    cmp("single_we_after", 64'(mem_we), 64'd0);
    cmp("single_pending_after", 64'(pending), 64'd0);

    // Auto-increment
    wr_log.delete();
    drv(1'b1, OP_WR, 32'h0000_00FF, 32'h1111_0000, 1'b1); tick();
    drv(1'b1, OP_WRI, 32'h0, 32'hAAAA_AAAA, 1'b1); tick();
    drv(1'b1, OP_WRI, 32'h0, 32'hBBBB_BBBB, 1'b1); tick();
    idle(4);
    check_log("autoinc", 16'h00FF, 16'h0100, 16'h0101);

    // Pointer wrap
    wr_log.delete();
    drv(1'b1, OP_WR, 32'h0000_FFFE, 32'h2222_0000, 1'b1); tick();
    drv(1'b1, OP_WRI, 32'h0, 32'h2222_0001, 1'b1); tick();
    drv(1'b1, OP_WRI, 32'h0, 32'h2222_0002, 1'b1); tick();
    idle(4);
    check_log("wrap", 16'hFFFE, 16'hFFFF, 16'h0000);

    // Full and backpressure
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, OP_WR, 32'h10 + 32'(i), 32'h3000 + 32'(i), 1'b0); tick();
    end
    drv(1'b1, OP_WR, 32'h14, 32'h3004, 1'b0);
    repeat (3) tick();
    cmp("full_pending", 64'(pending), 64'd4);
    cmp("full_stall", 64'(stall), 64'd1);
    mem_ready = 1'b1;
    tick();
    cmp("full_pop_no_accept", 64'(pending), 64'd3);
    tick();
    cmp("full_accept_and_pop", 64'(pending), 64'd3);
    idle(6);
    cmp("full_drain_count", 64'(wr_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) cmp("full_drain_order", 64'(wr_log[i]), 64'h10 + 64'(i));

    // Simultaneous accept and pop, then ignored opcode
    drv(1'b1, OP_WR, 32'h20, 32'h4000, 1'b0); tick();
    drv(1'b1, OP_WR, 32'h21, 32'h4001, 1'b0); tick();
    cmp("simul_pre_pending", 64'(pending), 64'd2);
    drv(1'b1, OP_WR, 32'h22, 32'h4002, 1'b1); tick();
    cmp("simul_pending", 64'(pending), 64'd2);
    cmp("simul_head", 64'(mem_addr), 64'h21);
    drv(1'b1, OP_NOP, 32'h99, 32'h9999, 1'b0); tick();
    cmp("nop_pending", 64'(pending), 64'd2);
    cmp("nop_head", 64'(mem_addr), 64'h21);
    drv(1'b1, OP_WRI, 32'h0, 32'h4003, 1'b0); tick();
    idle(6);

    // Reset mid-operation
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, OP_WR, 32'h30 + 32'(i), 32'h5000 + 32'(i), 1'b0); tick();
    end
    cmp("pre_reset_pending", 64'(pending), 64'd3);
    do_reset();
    tick();
    rst_n = 1'b1;
    drv(1'b1, OP_WR, 32'h40, 32'h6000, 1'b1);
    tick();
    cmp("post_reset_we", 64'(mem_we), 64'd1);
    cmp("post_reset_addr", 64'(mem_addr), 64'h40);
    idle(5);
    cmp("post_reset_writes", 64'(wr_log.size()), 64'd1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = OP_WR;
        4, 5, 6, 7: op = OP_WRI;
        default: begin
          op = 6'($urandom);
          if (op == OP_WR || op == OP_WRI) op = OP_NOP;
        end
      endcase
      drv(1'($urandom_range(0, 3) != 0), op,
          ($urandom_range(0, 3) == 0) ? {16'($urandom), 16'hFFFC + 16'($urandom_range(0, 3))} : $urandom,
          $urandom, 1'($urandom_range(0, 2) != 0));
      tick();
    end
    idle(DEPTH + 4);
    cmp("drain_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_write_queue.md
INST_WRITE_QUEUE -- requirements
Module: inst_write_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the instruction-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the write-data width.
REQ-003 The block SHALL have parameter DEPTH, default 4 (power of two, at least 2), giving the number of queue entries.
REQ-004 The block SHALL have parameter OP_WR, default 6'b001010, the write-at-rs opcode.
REQ-005 The block SHALL have parameter OP_WRI, default 6'b001011, the write-at-pointer-then-increment opcode.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port inst_valid, input, 1 bit: inst, rs and rt are valid this cycle.
REQ-009 The block SHALL have port inst, input, 32 bits: instruction word; opcode is inst[31:26].
REQ-010 The block SHALL have port rs, input, 32 bits: address operand; only rs[ADDR_W-1:0] is used.
REQ-011 The block SHALL have port rt, input, 32 bits: data operand; only rt[DATA_W-1:0] is used.
REQ-012 The block SHALL have port stall, output, 1 bit: queue full, so the upstream must hold its instruction.
REQ-013 The block SHALL have port mem_we, output, 1 bit: a write request is presented to instruction memory.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W bits: the write address.
REQ-015 The block SHALL have port mem_wdata, output, DATA_W bits: the write data.
REQ-016 The block SHALL have port mem_ready, input, 1 bit: memory accepts the presented write this cycle.
REQ-017 The block SHALL have port pending, output, clog2(DEPTH)+1 bits: the current number of occupied entries.

Function
REQ-018 A cycle SHALL be an accept when inst_valid=1, the opcode equals OP_WR or OP_WRI, and pending<DEPTH.
- Any other opcode SHALL be ignored, with no state change.
REQ-019 stall SHALL equal (pending==DEPTH); it is combinational from the count register.
- stall SHALL be independent of inst_valid, the opcode and mem_ready.
REQ-020 An OP_WR accept SHALL enqueue the pair {rs[ADDR_W-1:0], rt}.
- It SHALL also load the internal pointer with rs[ADDR_W-1:0]+1, wrapping modulo 2^ADDR_W.
REQ-021 An OP_WRI accept SHALL enqueue the pair {pointer, rt}.
- It SHALL then increment the pointer by 1, wrapping from 2^ADDR_W-1 to 0.
REQ-022 The pointer SHALL change only on accepts.
REQ-023 mem_we SHALL equal (pending!=0).
- mem_addr and mem_wdata SHALL present the head entry; their values are don't-care when mem_we=0.
REQ-024 A pop SHALL occur when mem_we=1 and mem_ready=1; the head advances on that edge.
- Head and tail indices SHALL wrap modulo DEPTH.
REQ-025 Latency from accept to first presentation on mem_we SHALL be exactly 1 cycle.
- An entry SHALL never bypass storage combinationally.
REQ-026 A simultaneous accept and pop SHALL leave pending unchanged and both operations SHALL complete.
- When the queue is full, no accept occurs because stall=1, even if a pop happens in that cycle.
REQ-027 Entries SHALL be written to memory strictly in accept order, each exactly once.
REQ-028 mem_we, mem_addr and mem_wdata SHALL hold stable while mem_ready=0.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously clear pending, head, tail and the pointer to 0.
- mem_we=0 and stall=0 SHALL follow directly from these cleared registers.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries, with no memory write issued for them.
REQ-031 Queue storage contents SHALL need no reset.
REQ-032 The first accept after rst_n rises SHALL be taken on the first rising edge with rst_n=1.

Verification
REQ-033 Single write: OP_WR with rs=0x0000_1234, rt=0xDEAD_BEEF, mem_ready=1.
- Required: the next cycle shows mem_we=1, mem_addr=0x1234, mem_wdata=0xDEADBEEF.
- Required: the cycle after that shows mem_we=0 and pending=0.
REQ-034 Auto-increment: OP_WR with rs=0x00FF, then OP_WRI with rt=A, then OP_WRI with rt=B.
- Required: writes go to 0x00FF, 0x0100, 0x0101, in that order.
REQ-035 Pointer wrap: OP_WR with rs=0xFFFE, then 2×OP_WRI.
- Required: writes go to 0xFFFE, 0xFFFF, 0x0000.
REQ-036 Full and backpressure: mem_ready=0 while 5 OP_WR are offered.
- Required: pending reaches 4 and stall=1; the 5th is not accepted until one cycle with mem_ready=1.
- Required: drain order matches offer order.
REQ-037 Simultaneous events: pending=2, then an accept and a pop in the same cycle.
- Required: pending stays 2 and the next head is the older entry.
- Required: a non-write opcode with inst_valid=1 changes nothing.
REQ-038 Reset mid-operation: rst_n pulsed low with pending=3.
- Required: mem_we=0 and pending=0 immediately, and no stale writes appear after release.
